// File: rtl/alu_seq.sv
// alu_seq: handshaked EX-stage ALU with single-cycle logic/shift/compare ops and
// iterative signed/unsigned multiply; divide is built only when ALU_SEQ_DIV_EN is defined.
module alu_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [4:0]       i_op,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_out_hi,
    output logic             o_zero
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_out, r_out_hi;
    logic [WIDTH-1:0]     r_acc, r_lo, r_b;
    logic [SHAMT_W-1:0]   r_cnt;
    logic                 r_is_div, r_neg_lo, r_neg_hi, r_div0;

    logic                 w_accept, w_is_mul, w_is_div, w_multi, w_signed;
    logic                 w_s1, w_s2;
    logic [WIDTH-1:0]     w_mag1, w_mag2, w_alu;
    logic [SHAMT_W-1:0]   w_sh;
    logic [WIDTH:0]       w_msum;
    logic [WIDTH-1:0]     w_mul_hi, w_mul_lo, w_div_hi, w_div_lo;
    logic [WIDTH-1:0]     w_step_hi, w_step_lo, w_fin_hi, w_fin_lo;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_accept = i_in_valid && o_in_ready;
    assign w_is_mul = (i_op == 5'h10) || (i_op == 5'h11);
    assign w_multi  = w_is_mul || w_is_div;
    assign w_signed = ~i_op[0];
    assign w_s1     = w_signed && i_in1[WIDTH-1];
    assign w_s2     = w_signed && i_in2[WIDTH-1];
    assign w_mag1   = w_s1 ? -i_in1 : i_in1;
    assign w_mag2   = w_s2 ? -i_in2 : i_in2;
    assign w_sh     = i_in1[SHAMT_W-1:0];

    always_comb begin
        w_alu = '0;
        case (i_op)
            5'h00: w_alu = i_in1 + i_in2;
            5'h01: w_alu = i_in1 - i_in2;
            5'h03: w_alu = i_in1 & i_in2;
            5'h04: w_alu = i_in1 | i_in2;
            5'h05: w_alu = i_in1 ^ i_in2;
            5'h06: w_alu = ~(i_in1 | i_in2);
            5'h07: w_alu = {{(WIDTH-1){1'b0}}, (i_in1 < i_in2)};
            5'h08: w_alu = {{(WIDTH-1){1'b0}}, ($signed(i_in1) < $signed(i_in2))};
            5'h09: w_alu = i_in2 << w_sh;
            5'h0A: w_alu = i_in2 >> w_sh;
            5'h0B: w_alu = $signed(i_in2) >>> w_sh;
            5'h0C: w_alu = {{(WIDTH-1){1'b0}}, (!i_in1[WIDTH-1] && (i_in1 != '0))};
            default: w_alu = '0;
        endcase
    end

    // Shift-add multiply: r_lo holds the multiplier and fills with product low bits.
    assign w_msum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_mul_hi = w_msum[WIDTH:1];
    assign w_mul_lo = {w_msum[0], r_lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0] w_dshift, w_ddiff;
    logic           w_dge;
    assign w_is_div = (i_op == 5'h12) || (i_op == 5'h13);
    // Restoring divide: r_acc is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_dshift = {r_acc, r_lo[WIDTH-1]};
    assign w_ddiff  = w_dshift - {1'b0, r_b};
    assign w_dge    = (w_dshift >= {1'b0, r_b});
    assign w_div_hi = w_dge ? w_ddiff[WIDTH-1:0] : w_dshift[WIDTH-1:0];
    assign w_div_lo = {r_lo[WIDTH-2:0], w_dge};
`else
    assign w_is_div = 1'b0;
    assign w_div_hi = '0;
    assign w_div_lo = '0;
`endif

    assign w_step_hi = r_is_div ? w_div_hi : w_mul_hi;
    assign w_step_lo = r_is_div ? w_div_lo : w_mul_lo;
    assign w_prod    = r_neg_lo ? -{w_step_hi, w_step_lo} : {w_step_hi, w_step_lo};

    // Divide-by-zero keeps the all-ones quotient; the remainder fix-up restores in1.
    always_comb begin
        if (r_is_div) begin
            w_fin_lo = r_div0 ? '1 : (r_neg_lo ? -w_step_lo : w_step_lo);
            w_fin_hi = r_neg_hi ? -w_step_hi : w_step_hi;
        end else begin
            w_fin_lo = w_prod[WIDTH-1:0];
            w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = w_multi ? S_BUSY : S_HOLD;
            end
            S_BUSY: begin
                if (r_cnt == '0) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                o_in_ready = i_out_ready;
                if (i_out_ready) begin
                    if (i_in_valid) w_state_nxt = w_multi ? S_BUSY : S_HOLD;
                    else            w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out    <= '0;
            r_out_hi <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_accept) begin
            if (w_multi) begin
                r_acc    <= '0;
                r_lo     <= w_mag1;
                r_b      <= w_mag2;
                r_cnt    <= SHAMT_W'(WIDTH-1);
                r_is_div <= w_is_div;
                r_neg_lo <= w_s1 ^ w_s2;
                r_neg_hi <= w_s1;
                r_div0   <= (i_in2 == '0);
            end else begin
                r_out    <= w_alu;
                r_out_hi <= '0;
            end
        end else if (r_state == S_BUSY) begin
            r_acc <= w_step_hi;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
                r_out    <= w_fin_lo;
                r_out_hi <= w_fin_hi;
            end
        end
    end

    assign o_out_valid = (r_state == S_HOLD);
    assign o_out       = r_out;
    assign o_out_hi    = r_out_hi;
    assign o_zero      = (r_out == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); divide vectors depend on ALU_SEQ_DIV_EN.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, zero;
    logic [4:0]  op;
    logic [31:0] in1, in2, out, out_hi;
    int          tests = 0;
    int          fails = 0;
    int          lat, rdy_low, stable;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32)) dut (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op(op), .i_in1(in1), .i_in2(in2), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out(out), .o_out_hi(out_hi), .o_zero(zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first out_valid cycle.
    task automatic do_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op = o; in1 = a; in2 = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in1 = $urandom; in2 = $urandom; op = 5'h1F;
        lat = 1;
        rdy_low = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) rdy_low++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic vec(input string tag, input logic [4:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        do_op(o, a, b);
        chk({tag, " lat"}, 64'(lat), 64'd1);
        chk({tag, " out"}, {out_hi, out}, {32'h0, exp});
        chk({tag, " zero"}, 64'(zero), 64'(exp == 32'h0));
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = 5'h0; in1 = 32'h0; in2 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out", {out_hi, out}, 64'h0);
        chk("rst zero", 64'(zero), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        vec("add wrap", 5'h00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);

        // Back-to-back with out_ready held high.
        in_valid = 1'b1; op = 5'h01; in1 = 32'd5; in2 = 32'd5;
        #1;
        chk("b2b in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        chk("b2b sub valid", 64'(out_valid), 64'd1);
        chk("b2b sub out", {out_hi, out}, 64'h0);
        chk("b2b sub zero", 64'(zero), 64'd1);
        op = 5'h0B; in1 = 32'd4; in2 = 32'h8000_0000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b sra valid", 64'(out_valid), 64'd1);
        chk("b2b sra out", {out_hi, out}, 64'h0000_0000_F800_0000);

        vec("and", 5'h03, 32'hF0F0, 32'hFF00, 32'hF000);
        vec("or", 5'h04, 32'hF0F0, 32'h0F00, 32'hFFF0);
        vec("xor", 5'h05, 32'hFFFF, 32'h0F0F, 32'hF0F0);
        vec("nor", 5'h06, 32'h0, 32'h0, 32'hFFFF_FFFF);
        vec("sltu", 5'h07, 32'h1, 32'hFFFF_FFFF, 32'h1);
        vec("slt", 5'h08, 32'h1, 32'hFFFF_FFFF, 32'h0);
        vec("sll", 5'h09, 32'd36, 32'h1, 32'h10);
        vec("srl", 5'h0A, 32'd4, 32'h8000_0000, 32'h0800_0000);
        vec("sgtz pos", 5'h0C, 32'd5, 32'h0, 32'h1);
        vec("sgtz neg", 5'h0C, 32'h8000_0000, 32'h0, 32'h0);
        vec("undef 02", 5'h02, 32'h1234, 32'h5678, 32'h0);

        // Signed multiply, then hold with out_ready low.
        do_op(5'h10, 32'hFFFF_FFFD, 32'd7);
        out_ready = 1'b0;
        chk("mult lat", 64'(lat), 64'd33);
        chk("mult in_ready low", 64'(rdy_low), 64'd32);
        chk("mult out", {out_hi, out}, 64'hFFFF_FFFF_FFFF_FFEB);
        stable = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid && !in_ready && out == 32'hFFFF_FFEB && out_hi == 32'hFFFF_FFFF) stable++;
        end
        chk("mult hold", 64'(stable), 64'd5);
        vec("after hold", 5'h00, 32'd1, 32'd1, 32'd2);

        do_op(5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu lat", 64'(lat), 64'd33);
        chk("multu out", {out_hi, out}, 64'hFFFF_FFFE_0000_0001);

`ifdef ALU_SEQ_DIV_EN
        do_op(5'h12, 32'hFFFF_FFF9, 32'd2);
        chk("div lat", 64'(lat), 64'd33);
        chk("div -7/2", {out_hi, out}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op(5'h13, 32'd9, 32'd0);
        chk("divu by 0", {out_hi, out}, 64'h0000_0009_FFFF_FFFF);
        do_op(5'h12, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div min/-1", {out_hi, out}, 64'h0000_0000_8000_0000);
        do_op(5'h13, 32'd9, 32'd3);
        chk("divu 9/3 lat", 64'(lat), 64'd33);
        chk("divu 9/3", {out_hi, out}, 64'h0000_0000_0000_0003);
`else
        do_op(5'h13, 32'd9, 32'd3);
        chk("nodiv lat", 64'(lat), 64'd1);
        chk("nodiv divu", {out_hi, out}, 64'h0);
        do_op(5'h12, 32'hFFFF_FFF9, 32'd2);
        chk("nodiv div", {out_hi, out}, 64'h0);
`endif

        // Reset ten cycles into a multu aborts it.
        in_valid = 1'b1; op = 5'h11; in1 = 32'd5; in2 = 32'd6;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort busy", 64'(in_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort out", {out_hi, out}, 64'h0);
        @(negedge clk);
        chk("abort stays idle", 64'(out_valid), 64'd0);
        vec("add after abort", 5'h00, 32'd2, 32'd3, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational CPU ALU: the same logical, shift and compare operations at WIDTH bits, plus iterative signed/unsigned multiply and divide producing a double-width result (out_hi:out). It sits in the EX stage. The pipeline holds the instruction while in_ready or out_valid is low.

## Interface
- WIDTH, 32: operand/result width; must be a power of two, at least 8.
- SHAMT_W, $clog2(WIDTH): shift-amount width (derived; not to be overridden).

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts operation this cycle
- op  in  5  operation code
- in1  in  WIDTH  operand 1 (shift amount for shifts)
- in2  in  WIDTH  operand 2 (shifted value for shifts)
- out_valid  out  1  result registered and held
- out_ready  in  1  consumer takes result this cycle
- out  out  WIDTH  low result / quotient
- out_hi  out  WIDTH  high product / remainder; 0 for single-cycle ops
- zero  out  1  out == 0

## Operation
- Op codes:
  - 0x00 add
  - 0x01 sub
  - 0x03 and
  - 0x04 or
  - 0x05 xor
  - 0x06 nor
  - 0x07 unsigned less-than
  - 0x08 signed less-than
  - 0x09 sll
  - 0x0A srl
  - 0x0B sra
  - 0x0C in1 > 0 signed
  - 0x10 mult (signed)
  - 0x11 multu
  - 0x12 div (signed)
  - 0x13 divu
  - Any other code: out = out_hi = 0, single-cycle.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH; no overflow flag.
  - Compares return 1 or 0 in bit 0, zero-extended.
  - Shifts: in2 shifted by in1[SHAMT_W-1:0]; sra sign-fills from in2[WIDTH-1].
- Handshake: transfer on in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready).
  - Operands are captured at acceptance; later input changes are ignored.
- FSM:
  - IDLE: accept a single-cycle op → HOLD; accept a mul/div → BUSY.
  - BUSY: count runs WIDTH-1 down to 0, one shift-add (mul) or one restoring subtract (div) per cycle; at count 0, apply sign fix-up, load out/out_hi → HOLD.
  - HOLD: out_valid=1, outputs stable.
    - out_ready && in_valid: accept the next op (back-to-back).
    - out_ready && !in_valid: → IDLE.
- Signed mul/div run on magnitudes.
  - Product sign = sign(in1) ^ sign(in2).
  - Quotient sign likewise; remainder takes the sign of in1.
- Divide boundaries:
  - Divisor 0: quotient = all ones, remainder = in1.
  - Signed MIN / -1: quotient = MIN, remainder = 0.
  - Both complete at normal latency.
- Reset (any state, including mid-BUSY) aborts the operation. State → IDLE; in-flight result is discarded.

## Timing
- Reset values:
  - out_valid = 0
  - out = 0
  - out_hi = 0
  - zero = 1
  - in_ready = 1 (cycle after reset deasserts)
- Single-cycle ops: accepted in cycle N, out_valid in N+1. Sustained throughput is 1/cycle with out_ready held high.
- Mul/div: accepted in cycle N, out_valid in N+WIDTH+1.
  - in_ready = 0 from N+1 through N+WIDTH.
- Outputs are registered, with no combinational path from inputs to out/out_hi/out_valid. in_ready depends combinationally on out_ready.
- The result is held indefinitely while out_ready = 0.

## Configuration
- ALU_SEQ_DIV_EN defined: the restoring divider is built; ops 0x12/0x13 behave as above.
- ALU_SEQ_DIV_EN undefined: no divider logic is built. 0x12/0x13 act as undefined codes: out = out_hi = 0, single-cycle.
- Multiply is always present.

## Test plan
- Reset, then add 0x7FFFFFFF + 1 with out_ready=1: out_valid in the next cycle, out = 0x80000000, out_hi = 0, zero = 0.
- Back-to-back, out_ready held 1: sub 5-5, then sra shamt 4 of 0x80000000. Results on consecutive cycles: 0 with zero=1, then 0xF8000000.
- mult of -3 and 7: in_ready low for 32 cycles, out_valid 33 cycles after acceptance, out_hi:out = 0xFFFFFFFF:0xFFFFFFEB. Holding out_ready=0 for 5 cycles keeps the values stable.
- With ALU_SEQ_DIV_EN defined:
  - div -7 / 2 → out = 0xFFFFFFFD, out_hi = 0xFFFFFFFF.
  - divu 9 / 0 → out = 0xFFFFFFFF, out_hi = 9.
  - div 0x80000000 / -1 → out = 0x80000000, out_hi = 0.
- Assert reset 10 cycles into a multu. The next cycle shows out_valid=0, in_ready=1, out=0. A following add 2+3 returns 5.
- Build without ALU_SEQ_DIV_EN: divu 9/3 returns out = 0, out_hi = 0 one cycle after acceptance.
